// File: rtl/cordic_magnitude_engine.sv
// cordic_magnitude_engine
//   Iterative vectoring-mode CORDIC computing sqrt(x^2 + y^2) of a signed
//   Q16.16 vector. It responds to the calculator's enable/operation/done
//   request handshake and services only the MOD operation (4'b0011).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   enable     request strobe, honoured only in IDLE or DONE
//   operation  op code; 4'b0011 computes, anything else flags op_err
//   x_in,y_in  signed Q16.16 operands, captured on the accepting edge
//   result     non-negative Q16.16 magnitude, held while done is high
//   done       level: result/op_err valid
//   op_err     last request carried an unsupported operation
module cordic_magnitude_engine #(
  parameter int              WIDTH      = 32,
  parameter int              ITERATIONS = 16,
  parameter logic [WIDTH-1:0] INV_GAIN  = 32'd39797
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             op_err
);

  // Two guard bits: one for |-2^(WIDTH-1)|, one for CORDIC gain growth (~1.65).
  localparam int XW   = WIDTH + 2;
  localparam int PW   = 2 * WIDTH + 2;
  localparam int CW   = $clog2(WIDTH) + 1;
  localparam int FRAC = 16;

  localparam logic [3:0]    OP_MOD   = 4'b0011;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERATIONS - 1);
  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_SCALE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic signed [XW-1:0]    x_q, x_d;
  logic signed [XW-1:0]    y_q, y_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic        [WIDTH-1:0] result_q, result_d;
  logic                    done_q, done_d;
  logic                    op_err_q, op_err_d;

  logic signed [XW-1:0]    x_ext, y_ext, x_abs;
  logic signed [XW-1:0]    x_shr, y_shr;
  logic signed [PW-1:0]    x_wide, gain_wide, prod, prod_shr;

  always_comb begin
    x_ext     = {{2{x_in[WIDTH-1]}}, x_in};
    y_ext     = {{2{y_in[WIDTH-1]}}, y_in};
    x_abs     = x_ext[XW-1] ? -x_ext : x_ext;
    x_shr     = x_q >>> cnt_q;
    y_shr     = y_q >>> cnt_q;
    x_wide    = {{(PW - XW){x_q[XW-1]}}, x_q};
    gain_wide = {{(PW - WIDTH){1'b0}}, INV_GAIN};
    prod      = x_wide * gain_wide;
    prod_shr  = prod >>> FRAC;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    op_err_d = op_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (enable) begin
          if (operation == OP_MOD) begin
            x_d      = x_abs;
            y_d      = y_ext;
            cnt_d    = '0;
            done_d   = 1'b0;
            op_err_d = 1'b0;
            state_d  = S_ITER;
          end else begin
            result_d = '0;
            op_err_d = 1'b1;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_ITER: begin
        // Drive y toward zero; x accumulates the (gain-scaled) magnitude.
        if (!y_q[XW-1]) begin
          x_d = x_q + y_shr;
          y_d = y_q - x_shr;
        end else begin
          x_d = x_q - y_shr;
          y_d = y_q + x_shr;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_SCALE;
        end
      end

      S_SCALE: begin
        if (prod_shr > SAT_MAX) begin
          result_d = SAT_MAX[WIDTH-1:0];
        end else begin
          result_d = prod_shr[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      op_err_q <= op_err_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign op_err = op_err_q;

endmodule
